// File: rtl/seg_disp_pkg.sv
// Shared constants, slot encodings and digit record for the multiplexed
// 7-segment display controller.
package seg_disp_pkg;

    localparam int DIGITS = 6;
    localparam int CNT_W  = 10;

    localparam logic [5:0] SEL_OFF = 6'h00;

    typedef enum logic [2:0] {
        SLOT0 = 3'd0,
        SLOT1 = 3'd1,
        SLOT2 = 3'd2,
        SLOT3 = 3'd3,
        SLOT4 = 3'd4,
        SLOT5 = 3'd5
    } slot_e;

    typedef struct packed {
        logic [3:0] nib;
        logic       dp;
    } digit_t;

    // Slot 0 is the leftmost digit, driven on the MSB of the select bus.
    function automatic logic [5:0] slot_to_sel(input slot_e k);
        return 6'h20 >> k;
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Scan prescaler and digit slot FSM: each slot lasts 2**CNT_W clocks,
// slots run SLOT0..SLOT5 and wrap.
module seg_scan_timer #(
    parameter int CNT_W = seg_disp_pkg::CNT_W
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    output seg_disp_pkg::slot_e slot_o,
    output logic [CNT_W-1:0]    cnt_o,
    output logic                tc_o,
    output logic                frame_end_o
);
    import seg_disp_pkg::*;

    slot_e            slot_q, slot_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign cnt_d = cnt_q + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            slot_q <= SLOT0;
        end else begin
            cnt_q  <= cnt_d;
            slot_q <= slot_d;
        end
    end

    always_comb begin
        slot_d = slot_q;
        if (tc_o) begin
            unique case (slot_q)
                SLOT0:   slot_d = SLOT1;
                SLOT1:   slot_d = SLOT2;
                SLOT2:   slot_d = SLOT3;
                SLOT3:   slot_d = SLOT4;
                SLOT4:   slot_d = SLOT5;
                SLOT5:   slot_d = SLOT0;
                default: slot_d = SLOT0;
            endcase
        end
    end

    assign tc_o        = &cnt_q;
    assign frame_end_o = tc_o && (slot_q == SLOT5);
    assign slot_o      = slot_q;
    assign cnt_o       = cnt_q;

endmodule

// File: rtl/seg_display_ctrl.sv
// Multiplexed 6-digit 7-segment controller: shadow/active digit buffers,
// frame-aligned commit, leading-zero blanking, PWM brightness, registered outputs.
module seg_display_ctrl #(
    parameter int DIGITS = seg_disp_pkg::DIGITS,
    parameter int CNT_W  = seg_disp_pkg::CNT_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_en_i,
    input  logic [2:0]        wr_addr_i,
    input  logic [3:0]        wr_data_i,
    input  logic              wr_dp_i,
    input  logic              wr_commit_i,
    output logic              wr_ready_o,
    input  logic              blank_lz_i,
    input  logic [3:0]        bright_i,
    output logic [3:0]        d_o,
    output logic              dp_o,
    output logic [DIGITS-1:0] seg_sel_o,
    output logic              frame_done_o
);
    import seg_disp_pkg::*;

    slot_e            slot;
    logic [CNT_W-1:0] cnt;
    logic             tc;
    logic             frame_end;

    seg_scan_timer #(
        .CNT_W (CNT_W)
    ) u_scan_timer (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .slot_o      (slot),
        .cnt_o       (cnt),
        .tc_o        (tc),
        .frame_end_o (frame_end)
    );

    digit_t shadow_q [DIGITS];
    digit_t shadow_d [DIGITS];
    digit_t active_q [DIGITS];
    digit_t active_d [DIGITS];
    logic   pending_q, pending_d;
    logic   commit_now;

    assign commit_now = pending_q && tc && (slot == SLOT5);

    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (wr_en_i && !pending_q && (wr_addr_i == 3'(i))) begin
                shadow_d[i] = {wr_data_i, wr_dp_i};
            end
        end
        if (wr_commit_i && !pending_q) begin
            pending_d = 1'b1;
        end
        // Active buffer only ever changes on the frame boundary, so a frame never tears.
        if (commit_now) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
    end

    // Compare the full counter against {bright, all-ones}: same as top nibble <= bright.
    logic [CNT_W-1:0] bright_lim;

    always_comb begin
        bright_lim = '1;
        for (int j = 0; j < 4; j++) begin
            bright_lim[CNT_W-4+j] = bright_i[j];
        end
    end

    logic [3:0]        d_d, d_q;
    logic              dp_d, dp_q;
    logic [DIGITS-1:0] sel_d, sel_q;
    logic              fd_q;
    logic              blank;
    logic              lead_zero;

    // A zero digit carrying a dp stays blank itself but stops blanking to its right.
    always_comb begin
        d_d       = 4'h0;
        dp_d      = 1'b0;
        blank     = 1'b0;
        lead_zero = blank_lz_i;
        for (int i = 0; i < DIGITS; i++) begin
            if (slot == slot_e'(3'(i))) begin
                d_d   = active_q[i].nib;
                dp_d  = active_q[i].dp;
                blank = lead_zero && (active_q[i].nib == 4'h0) && (i != DIGITS - 1);
            end
            lead_zero = lead_zero && (active_q[i].nib == 4'h0) && !active_q[i].dp;
        end
        sel_d = (blank || (cnt > bright_lim)) ? SEL_OFF : slot_to_sel(slot);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shadow_q  <= '{default: '0};
            active_q  <= '{default: '0};
            pending_q <= 1'b0;
            d_q       <= 4'h0;
            dp_q      <= 1'b0;
            sel_q     <= SEL_OFF;
            fd_q      <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            d_q       <= d_d;
            dp_q      <= dp_d;
            sel_q     <= sel_d;
            fd_q      <= frame_end;
        end
    end

    assign wr_ready_o   = !pending_q;
    assign d_o          = d_q;
    assign dp_o         = dp_q;
    assign seg_sel_o    = sel_q;
    assign frame_done_o = fd_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed bench for seg_display_ctrl with a 16-cycle slot (96-cycle frame).
// t counts rising edges since reset release; a sample at t shows cycle t-1.
module tb_seg_display_ctrl;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic       wr_dp;
    logic       wr_commit;
    logic       wr_ready;
    logic       blank_lz;
    logic [3:0] bright;
    logic [3:0] d;
    logic       dp;
    logic [5:0] seg_sel;
    logic       frame_done;

    int total = 0;
    int bad   = 0;
    int t     = 0;
    int on_cnt;

    int sel_exp  [6] = '{32'h20, 32'h10, 32'h08, 32'h04, 32'h02, 32'h01};
    int blk_sel  [6] = '{32'h00, 32'h00, 32'h00, 32'h04, 32'h02, 32'h01};
    int blk_d    [6] = '{0, 0, 0, 4, 0, 7};
    int zero_sel [6] = '{32'h00, 32'h00, 32'h00, 32'h00, 32'h00, 32'h01};
    int drop_d   [6] = '{5, 0, 0, 0, 0, 0};

    seg_display_ctrl #(
        .DIGITS (6),
        .CNT_W  (4)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .wr_en_i      (wr_en),
        .wr_addr_i    (wr_addr),
        .wr_data_i    (wr_data),
        .wr_dp_i      (wr_dp),
        .wr_commit_i  (wr_commit),
        .wr_ready_o   (wr_ready),
        .blank_lz_i   (blank_lz),
        .bright_i     (bright),
        .d_o          (d),
        .dp_o         (dp),
        .seg_sel_o    (seg_sel),
        .frame_done_o (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h at t=%0d", tag, obs, exp, t);
        end
    endtask

    task automatic step();
        @(posedge clk);
        t++;
        @(negedge clk);
    endtask

    task automatic goto(input int n);
        while (t < n) step();
    endtask

    task automatic wr(input int a, input int v, input bit p);
        wr_en   = 1'b1;
        wr_addr = a[2:0];
        wr_data = v[3:0];
        wr_dp   = p;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic commit();
        wr_commit = 1'b1;
        step();
        wr_commit = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 4'd0; wr_dp = 1'b0;
        wr_commit = 1'b0; blank_lz = 1'b0; bright = 4'd15;
        repeat (3) @(negedge clk);

        chk("rst_sel", 32'(seg_sel), 32'h00);
        chk("rst_d", 32'(d), 0);
        chk("rst_dp", 32'(dp), 0);
        chk("rst_fd", 32'(frame_done), 0);
        chk("rst_ready", 32'(wr_ready), 1);

        // Plain scan with an empty buffer
        rst_n = 1'b1;
        t = 0;
        for (int k = 0; k < 6; k++) begin
            goto(16 * k + 1);
            chk("scan_sel_first", 32'(seg_sel), sel_exp[k]);
            chk("scan_d", 32'(d), 0);
            if (k == 5) begin
                goto(95);
                chk("fd_before", 32'(frame_done), 0);
            end
            goto(16 * k + 16);
            chk("scan_sel_last", 32'(seg_sel), sel_exp[k]);
        end
        chk("fd_pulse", 32'(frame_done), 1);
        goto(97);
        chk("fd_after", 32'(frame_done), 0);
        chk("wrap_sel", 32'(seg_sel), 32'h20);

        // Write 1..6, commit mid-frame; display holds until the frame ends
        for (int i = 0; i < 6; i++) wr(i, i + 1, 1'b0);
        commit();
        chk("pend_ready", 32'(wr_ready), 0);
        goto(160);
        chk("hold_sel", 32'(seg_sel), 32'h04);
        chk("hold_d", 32'(d), 0);
        goto(191);
        chk("pend_ready_end", 32'(wr_ready), 0);
        goto(192);
        chk("commit_ready", 32'(wr_ready), 1);
        chk("commit_fd", 32'(frame_done), 1);
        chk("commit_old_d", 32'(d), 0);
        for (int k = 0; k < 6; k++) begin
            goto(193 + 16 * k);
            chk("new_sel", 32'(seg_sel), sel_exp[k]);
            chk("new_d", 32'(d), k + 1);
        end

        // Leading-zero blanking: 0,0,0,4,0,7 then all zeros
        blank_lz = 1'b1;
        for (int i = 0; i < 6; i++) wr(i, blk_d[i], 1'b0);
        commit();
        for (int k = 0; k < 6; k++) begin
            goto(385 + 16 * k);
            chk("blank_sel", 32'(seg_sel), blk_sel[k]);
            chk("blank_d", 32'(d), blk_d[k]);
        end
        for (int i = 0; i < 6; i++) wr(i, 0, 1'b0);
        commit();
        for (int k = 0; k < 6; k++) begin
            goto(481 + 16 * k);
            chk("zero_sel", 32'(seg_sel), zero_sel[k]);
        end
        blank_lz = 1'b0;

        // Brightness: count lit cycles over one full slot
        goto(576);
        bright = 4'd3;
        on_cnt = 0;
        repeat (16) begin step(); if (seg_sel != 6'h00) on_cnt++; end
        chk("bright3_on", on_cnt, 4);
        bright = 4'd15;
        on_cnt = 0;
        repeat (16) begin step(); if (seg_sel != 6'h00) on_cnt++; end
        chk("bright15_on", on_cnt, 16);
        bright = 4'd0;
        on_cnt = 0;
        repeat (16) begin step(); if (seg_sel != 6'h00) on_cnt++; end
        chk("bright0_on", on_cnt, 1);
        bright = 4'd15;

        // Out-of-range address, commit in the frame-end cycle, write while pending
        wr(7, 9, 1'b1);
        goto(671);
        wr_commit = 1'b1;
        wr(0, 5, 1'b0);
        wr_commit = 1'b0;
        chk("fe_commit_fd", 32'(frame_done), 1);
        chk("fe_commit_ready", 32'(wr_ready), 0);
        wr(1, 8, 1'b1);
        chk("no_early_copy_d", 32'(d), 0);
        chk("no_early_copy_sel", 32'(seg_sel), 32'h20);
        goto(767);
        chk("wait_frame_ready", 32'(wr_ready), 0);
        goto(768);
        chk("late_commit_ready", 32'(wr_ready), 1);
        for (int k = 0; k < 6; k++) begin
            goto(769 + 16 * k);
            chk("drop_d", 32'(d), drop_d[k]);
            chk("drop_dp", 32'(dp), 0);
        end

        // Asynchronous reset mid-slot3 with a commit pending
        goto(866);
        wr(2, 3, 1'b0);
        commit();
        chk("pre_rst_ready", 32'(wr_ready), 0);
        goto(920);
        chk("pre_rst_sel", 32'(seg_sel), 32'h04);
        chk("pre_rst_pend", 32'(wr_ready), 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_sel", 32'(seg_sel), 32'h00);
        chk("arst_d", 32'(d), 0);
        chk("arst_dp", 32'(dp), 0);
        chk("arst_fd", 32'(frame_done), 0);
        chk("arst_ready", 32'(wr_ready), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        t = 0;
        step();
        chk("post_rst_sel", 32'(seg_sel), 32'h20);
        chk("post_rst_active", 32'(d), 0);
        commit();
        chk("post_rst_pend", 32'(wr_ready), 0);
        goto(16);
        chk("post_rst_slot0_end", 32'(seg_sel), 32'h20);
        goto(17);
        chk("post_rst_slot1", 32'(seg_sel), 32'h10);
        goto(96);
        chk("post_rst_commit", 32'(wr_ready), 1);
        goto(129);
        chk("shadow_cleared_sel", 32'(seg_sel), 32'h08);
        chk("shadow_cleared_d", 32'(d), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
